// File: rtl/ulx3s_pll_pkg.sv
// Shared definitions for the ECP5 EHXPLLL dynamic phase controller.
// Holds the PHASESEL/PHASEDIR encodings, the sequencer state type and a
// small constant helper used to size counters.
package ulx3s_pll_pkg;

  // PHASESEL1:0 output selection
  localparam logic [1:0] SEL_CLKOS  = 2'b00;
  localparam logic [1:0] SEL_CLKOS2 = 2'b01;
  localparam logic [1:0] SEL_CLKOS3 = 2'b10;
  localparam logic [1:0] SEL_CLKOP  = 2'b11;

  // PHASEDIR
  localparam logic DIR_DELAY   = 1'b0;
  localparam logic DIR_ADVANCE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STEP_LO,
    ST_STEP_HI,
    ST_SETTLE,
    ST_FIN
  } pll_state_e;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ulx3s_lock_filter.sv
// LOCK qualifier: 2-flop synchronizer on the asynchronous PLL LOCK pin plus a
// consecutive-high counter that only runs while en is high.
// Ports:
//   clock, reset_n  reference clock, synchronous active-low reset
//   lock_async      raw PLL LOCK
//   en              counting window (SETTLE); counter held at 0 otherwise
//   stable          high in the LOCK_CYC-th consecutive synchronized high cycle
module ulx3s_lock_filter #(
  parameter int LOCK_CYC = 16,
  parameter int CNT_W    = 5
) (
  input  logic clock,
  input  logic reset_n,
  input  logic lock_async,
  input  logic en,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(LOCK_CYC - 1);

  logic             meta;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta   <= 1'b0;
      lock_s <= 1'b0;
      cnt    <= '0;
    end else begin
      meta   <= lock_async;
      lock_s <= meta;
      // Any low cycle restarts the run; saturate so stable stays asserted.
      if (!en || !lock_s)     cnt <= '0;
      else if (cnt != CNT_TOP) cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt holds the number of earlier high cycles, so the current high cycle
  // completes the run when cnt has reached LOCK_CYC-1.
  assign stable = en && lock_s && (cnt == CNT_TOP);

endmodule

// File: rtl/ulx3s_pll_phase_ctrl.sv
// Dynamic fine-phase step sequencer for an ECP5 EHXPLLL, running in the PLL
// reference-clock domain. One accepted request moves one PLL output by
// req_steps 1/8-VCO steps, then waits for LOCK to settle.
// Ports:
//   clock, reset_n                 reference clock, synchronous active-low reset
//   req_valid/req_ready            request handshake (sel, dir, steps)
//   pll_locked                     raw PLL LOCK (asynchronous)
//   pll_phasesel/dir/step/load     EHXPLLL dynamic phase pins
//   busy, done, lock_err           status; done is a one-cycle pulse, lock_err sticky
//   steps_issued                   PHASESTEP pulses issued for current/last request
module ulx3s_pll_phase_ctrl
  import ulx3s_pll_pkg::*;
#(
  parameter int STEP_W       = 8,
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 2,
  parameter int GAP_CYC      = 4,
  parameter int LOCK_CYC     = 16,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  input  logic              pll_locked,
  output logic [1:0]        pll_phasesel,
  output logic              pll_phasedir,
  output logic              pll_phasestep,
  output logic              pll_phaseload,
  output logic              busy,
  output logic              done,
  output logic              lock_err,
  output logic [STEP_W-1:0] steps_issued
);

  localparam int CNT_W = $clog2(max_of(max_of(SETUP_CYC, PULSE_CYC),
                           max_of(max_of(GAP_CYC, LOCK_CYC), LOCK_TIMEOUT))) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

  pll_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_q;       // shared SETUP/PULSE/GAP down-counter
  logic [CNT_W-1:0]  settle_q;     // cycles spent in SETTLE
  logic [STEP_W-1:0] remaining_q;
  logic [STEP_W-1:0] steps_q;
  logic [1:0]        sel_q;
  logic              dir_q;
  logic              err_q;

  logic              accept;
  logic              wait_ld;
  logic [CNT_W-1:0]  wait_val;
  logic              step_exit;
  logic              timeout;
  logic              stable;

  ulx3s_lock_filter #(.LOCK_CYC(LOCK_CYC), .CNT_W(CNT_W)) u_lock (
    .clock      (clock),
    .reset_n    (reset_n),
    .lock_async (pll_locked),
    .en         (state_q == ST_SETTLE),
    .stable     (stable)
  );

  assign done          = (state_q == ST_FIN);
  assign busy          = (state_q != ST_IDLE);
  assign req_ready     = reset_n && (state_q == ST_IDLE) && !done;
  assign accept        = req_valid && req_ready;
  assign pll_phasestep = (state_q != ST_STEP_LO);
  assign pll_phaseload = 1'b1;
  assign pll_phasesel  = sel_q;
  assign pll_phasedir  = dir_q;
  assign lock_err      = err_q;
  assign steps_issued  = steps_q;

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wait_ld   = 1'b0;
    wait_val  = '0;
    step_exit = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d  = ST_SETUP;
        wait_ld  = 1'b1;
        wait_val = SETUP_LD;
      end
      ST_SETUP: if (wait_q == '0) begin
        if (remaining_q != '0) begin
          state_d  = ST_STEP_LO;
          wait_ld  = 1'b1;
          wait_val = PULSE_LD;
        end else begin
          state_d  = ST_FIN;    // zero steps: no pulse and no settle wait
        end
      end
      ST_STEP_LO: if (wait_q == '0) begin
        state_d   = ST_STEP_HI;
        wait_ld   = 1'b1;
        wait_val  = GAP_LD;
        step_exit = 1'b1;
      end
      ST_STEP_HI: if (wait_q == '0) begin
        if (remaining_q != '0) begin
          state_d  = ST_STEP_LO;
          wait_ld  = 1'b1;
          wait_val = PULSE_LD;
        end else begin
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // A settle in the final allowed cycle wins over the timeout.
        if (stable) begin
          state_d = ST_FIN;
        end else if (settle_q == TO_LAST) begin
          state_d = ST_FIN;
          timeout = 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_q      <= '0;
      settle_q    <= '0;
      remaining_q <= '0;
      steps_q     <= '0;
      sel_q       <= SEL_CLKOS;
      dir_q       <= DIR_ADVANCE;
      err_q       <= 1'b0;
    end else begin
      if (wait_ld)             wait_q <= wait_val;
      else if (wait_q != '0)   wait_q <= wait_q - CNT_W'(1);

      if (state_q == ST_SETTLE) settle_q <= settle_q + CNT_W'(1);
      else                      settle_q <= '0;

      if (accept) begin
        sel_q       <= req_sel;
        dir_q       <= req_dir;
        remaining_q <= req_steps;
        steps_q     <= '0;
        err_q       <= 1'b0;
      end

      // Only reached with remaining_q != 0, so no underflow.
      if (step_exit) begin
        remaining_q <= remaining_q - STEP_W'(1);
        steps_q     <= steps_q + STEP_W'(1);
      end

      if (timeout) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ulx3s_pll_phase_ctrl.sv
// Bench for ulx3s_pll_phase_ctrl: a PLL LOCK model (drops for 10 cycles after
// each step), a transaction-level reference model compared every cycle, and
// directed plus randomized requests with literal timing anchors.
module tb_ulx3s_pll_phase_ctrl;
  import ulx3s_pll_pkg::*;

  localparam int STEP_W = 8;
  localparam int S      = 2;
  localparam int P      = 2;
  localparam int G      = 4;
  localparam int LC     = 16;
  localparam int TO     = 4096;
  localparam int HMAX   = 32768;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_sel = 2'b00;
  logic              req_dir = 1'b0;
  logic [STEP_W-1:0] req_steps = '0;
  logic              pll_locked = 1'b0;
  logic [1:0]        pll_phasesel;
  logic              pll_phasedir, pll_phasestep, pll_phaseload;
  logic              busy, done, lock_err;
  logic [STEP_W-1:0] steps_issued;

  ulx3s_pll_phase_ctrl #(
    .STEP_W(STEP_W), .SETUP_CYC(S), .PULSE_CYC(P), .GAP_CYC(G),
    .LOCK_CYC(LC), .LOCK_TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps),
    .pll_locked(pll_locked),
    .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir),
    .pll_phasestep(pll_phasestep), .pll_phaseload(pll_phaseload),
    .busy(busy), .done(done), .lock_err(lock_err), .steps_issued(steps_issued)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- PLL LOCK environment ----------------
  int drop = 0;
  bit force_low = 1'b0;
  bit noise = 1'b0;
  int glitch_at = -100;
  int glitch_len = 0;

  always @(negedge clock) begin
    if (pll_phasestep === 1'b0) drop = 10;
    else if (drop > 0)          drop--;
  end

  always @(posedge clock) begin
    #2;
    pll_locked = (drop == 0) && !force_low &&
                 !(cyc >= glitch_at && cyc < glitch_at + glitch_len) &&
                 !(noise && ($urandom_range(0, 15) == 0));
  end

  // ---------------- reference model ----------------
  bit lk_hist [HMAX];
  bit rst_hist[HMAX];

  bit         m_active = 1'b0, m_has = 1'b0, m_err = 1'b0, m_err_pend = 1'b0;
  int         m_A = 0, m_N = 0, m_T = 0, m_fin = -1;
  logic [1:0] m_sel = 2'b00;
  logic       m_dir = 1'b1;

  // LOCK as seen after the two-flop synchronizer in cycle c.
  function automatic bit sync_at(input int c);
    if (c < 3 || c - 2 >= HMAX) return 1'b0;
    if (rst_hist[c-1] || rst_hist[c-2]) return 1'b0;
    return lk_hist[c-2];
  endfunction

  // True when the last LC synchronized samples, all inside SETTLE, are high.
  function automatic bit win_ok(input int c);
    if (c - LC + 1 < m_T) return 1'b0;
    for (int j = c - LC + 1; j <= c; j++)
      if (!sync_at(j)) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clock) begin
    int c, off, e_si;
    bit e_busy, e_done, e_ready, e_step;
    c = cyc;
    if (c < HMAX) begin
      lk_hist[c]  = pll_locked;
      rst_hist[c] = !reset_n;
    end
    if (m_active && m_fin < 0 && m_N > 0 && c >= m_T) begin
      if (win_ok(c)) m_fin = c + 1;
      else if (c == m_T + TO - 1) begin
        m_fin = c + 1;
        m_err_pend = 1'b1;
      end
    end
    if (m_active && c == m_fin) m_err = m_err_pend;
    e_busy  = m_active;
    e_done  = m_active && (c == m_fin);
    e_ready = reset_n && !m_active;
    e_step  = 1'b1;
    e_si    = 0;
    if (m_has) begin
      off = c - (m_A + 1 + S);
      if (m_active && m_N > 0 && off >= 0 && off < m_N * (P + G) && (off % (P + G)) < P)
        e_step = 1'b0;
      if (off >= P) begin
        e_si = (off - P) / (P + G) + 1;
        if (e_si > m_N) e_si = m_N;
      end
    end
    if (c >= 1) begin
      chk("busy",          busy,          e_busy);
      chk("done",          done,          e_done);
      chk("req_ready",     req_ready,     e_ready);
      chk("phasestep",     pll_phasestep, e_step);
      chk("phaseload",     pll_phaseload, 1);
      chk("phasesel",      pll_phasesel,  m_sel);
      chk("phasedir",      pll_phasedir,  m_dir);
      chk("lock_err",      lock_err,      m_err);
      chk("steps_issued",  steps_issued,  e_si);
    end
    if (e_done) m_active = 1'b0;
    if (!reset_n) begin
      m_active = 1'b0; m_has = 1'b0; m_err = 1'b0; m_err_pend = 1'b0;
      m_sel = 2'b00; m_dir = 1'b1;
    end else if (e_ready && req_valid) begin
      m_active = 1'b1; m_has = 1'b1;
      m_A = c; m_N = int'(req_steps);
      m_T = c + 1 + S + m_N * (P + G);
      m_fin = (m_N == 0) ? c + 1 + S : -1;
      m_sel = req_sel; m_dir = req_dir;
      m_err = 1'b0; m_err_pend = 1'b0;
    end
  end

  // ---------------- observation for literal anchors ----------------
  int lo_cnt = 0, last_lo = -1, done_cnt = 0;
  always @(negedge clock) begin
    if (pll_phasestep === 1'b0) begin
      lo_cnt++;
      last_lo = cyc;
    end
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [1:0] s, input logic d, input int n, output int acc);
    acc = -1;
    @(posedge clock); #1;
    req_valid = 1'b1; req_sel = s; req_dir = d; req_steps = STEP_W'(n);
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", 0, 1);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog @cyc %0d: got running, want finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, dc, lo0, d0, g, a2;
    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_step", pll_phasestep, 1);
    chk("rst_sel", pll_phasesel, 0);
    chk("rst_dir", pll_phasedir, 1);
    chk("rst_ready", req_ready, 0);
    @(posedge clock); #1; reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("idle_ready", req_ready, 1);

    // 3 steps on CLKOS2, advance
    lo0 = lo_cnt;
    send(SEL_CLKOS2, DIR_ADVANCE, 3, a);
    wait_done(300, dc);
    chk("s3_low_cycles", lo_cnt - lo0, 6);
    chk("s3_latency", dc - a, 45);
    chk("s3_settle_ge16", (dc - last_lo >= 16) ? 1 : 0, 1);
    chk("s3_steps", steps_issued, 3);
    chk("s3_err", lock_err, 0);

    // zero steps
    lo0 = lo_cnt;
    send(SEL_CLKOP, DIR_DELAY, 0, a);
    wait_done(50, dc);
    chk("s0_latency", dc - a, 1 + S);
    chk("s0_low_cycles", lo_cnt - lo0, 0);
    chk("s0_steps", steps_issued, 0);

    // LOCK stuck low -> timeout
    force_low = 1'b1;
    send(SEL_CLKOS3, DIR_DELAY, 1, a);
    wait_done(TO + 200, dc);
    chk("to_latency", dc - a, 1 + S + (P + G) + TO);
    chk("to_err", lock_err, 1);
    force_low = 1'b0;
    repeat (5) @(posedge clock);
    send(SEL_CLKOS, DIR_ADVANCE, 0, a);
    @(negedge clock);
    chk("err_cleared", lock_err, 0);
    wait_done(50, dc);

    // single glitch mid-SETTLE restarts the count
    repeat (5) @(posedge clock);
    send(SEL_CLKOS2, DIR_DELAY, 1, a);
    g = a + 24;
    glitch_at = g; glitch_len = 2;
    wait_done(300, dc);
    chk("glitch_done", dc, g + 2 + 2 + LC);
    chk("glitch_err", lock_err, 0);

    // valid held through busy with new fields
    @(posedge clock); #1;
    req_valid = 1'b1; req_sel = SEL_CLKOS3; req_dir = DIR_ADVANCE; req_steps = 8'd2;
    a = -1;
    for (int k = 0; k < 20 && a < 0; k++) begin
      @(negedge clock);
      if (req_ready) a = cyc;
    end
    @(posedge clock); #1;
    req_sel = SEL_CLKOP; req_dir = DIR_DELAY; req_steps = 8'd1;
    wait_done(300, dc);
    a2 = -1;
    for (int k = 0; k < 5 && a2 < 0; k++) begin
      @(negedge clock);
      if (req_ready) a2 = cyc;
    end
    chk("b2b_accept", a2, dc + 1);
    @(posedge clock); #1; req_valid = 1'b0;
    @(negedge clock);
    chk("b2b_sel", pll_phasesel, SEL_CLKOP);
    wait_done(300, dc);
    chk("b2b_steps", steps_issued, 1);

    // reset during STEP_LO
    send(SEL_CLKOS2, DIR_ADVANCE, 3, a);
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (!pll_phasestep) break;
    end
    @(posedge clock); #1; reset_n = 1'b0;
    @(posedge clock); #1; reset_n = 1'b1;
    d0 = done_cnt;
    @(negedge clock);
    chk("rstmid_step", pll_phasestep, 1);
    chk("rstmid_busy", busy, 0);
    repeat (20) @(negedge clock);
    chk("rstmid_nodone", done_cnt - d0, 0);
    chk("rstmid_ready", req_ready, 1);
    send(SEL_CLKOS3, DIR_DELAY, 2, a);
    wait_done(300, dc);
    chk("rstmid_steps", steps_issued, 2);

    // maximum step count
    lo0 = lo_cnt;
    send(SEL_CLKOS, DIR_DELAY, 255, a);
    wait_done(2000, dc);
    chk("max_steps", steps_issued, 255);
    chk("max_low_cycles", lo_cnt - lo0, 510);

    // randomized requests with noisy LOCK
    noise = 1'b1;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clock);
      send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 6), a);
      wait_done(TO + 200, dc);
    end
    noise = 1'b0;

    repeat (5) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
